time_update_seq: RTL and testbench
==================================

Name: time_update_seq

Overview:
- Parametrised successor to the clock's time-update PLA controller.
- Combines three things: an internal 1 Hz prescaler; a ripple-carry sequencer that advances sec→min→hour→day→month→year, one field per clock; and a user SET mode with up/down adjust of any selected field.
- Sits between the board clock and the display/BCD formatting stage. Outputs binary field values.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per second tick. Minimum 8.
- YEAR_SPAN, 100: year counter modulus. Year offset runs 0..YEAR_SPAN-1, meaning 2000..2000+YEAR_SPAN-1.
- YEAR_W, 7: width of the year offset; must satisfy 2^YEAR_W ≥ YEAR_SPAN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- set_mode  in  1  1 = SET mode; tick counting suspended.
- field_sel  in  3  SET target: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; 6 and 7 ignored.
- inc  in  1  one-cycle request: +1 to the selected field (SET mode only).
- dec  in  1  one-cycle request: -1 to the selected field (SET mode only).
- sec  out  6  0..59
- min  out  6  0..59
- hour  out  5  0..23
- day  out  5  1..days_in_month
- month  out  4  1..12
- year  out  YEAR_W  offset 0..YEAR_SPAN-1
- busy  out  1  high while the sequencer is not in IDLE.
- upd_done  out  1  one-cycle pulse when a carry chain or SET edit completes.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset values, synchronous, all outputs: sec=0, min=0, hour=0, day=1, month=1, year=0, busy=0, upd_done=0. State=IDLE, prescaler=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while set_mode=0. tick=1 for one cycle at count TICK_DIV-1, then wraps to 0.
  - Held at 0 while set_mode=1.
- FSM states: IDLE, SEC, MIN, HOUR, DAY, MON, YEAR, CLAMP.
- IDLE:
  - tick → SEC.
  - In set_mode, inc XOR dec with a valid field_sel: the edit is applied at that edge, then → CLAMP.
  - inc and dec both high, or field_sel ≥6: no-op.
- SEC/MIN/HOUR/DAY/MON/YEAR, one edge each:
  - Increment the field.
  - If it hits its maximum, wrap to its minimum and → next state. Otherwise → IDLE with upd_done=1 on the following cycle.
  - YEAR always returns to IDLE: YEAR_SPAN-1 wraps to 0.
- Latency:
  - Tick sampled at edge k → sec updated at edge k+1.
  - Each extra carry stage adds one edge. Worst case (full year rollover) is 6 edges after tick.
- Run-mode day carry:
  - Uses days_in_month(month, year): 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; Feb per the optional feature.
  - DAY wraps to 1. MON wraps 12→1.
- SET edit:
  - Field wraps within its own range, with no carry to neighbours. Dec wraps low→high, e.g. min 0→59, month 1→12, day 1→days_in_month.
  - CLAMP, one cycle: if day > days_in_month, day := days_in_month. Then → IDLE, upd_done=1.
- Requests while busy:
  - inc/dec while busy=1 are dropped, not queued.
  - set_mode rising mid-chain: the chain completes first, then ticks stop.
- set_mode falling: prescaler restarts from 0, so the first tick comes TICK_DIV cycles later.
- Reset mid-chain: returns immediately to reset values. No partial carry survives.
- Ticks: TICK_DIV ≥ 8 guarantees a chain finishes before the next tick, so ticks are never lost.

Optional Feature:
- Macro: TIME_UPDATE_SEQ_LEAP_EN.
- Defined: February has 29 days when year offset mod 4 == 0, else 28. This is exact for 2000..2099.
- Undefined: February always has 28 days, and the leap logic is not synthesised.
- CLAMP and run-mode carry both use the same days_in_month function, so behaviour is consistent in both modes.

Test Plan:
- Reset, then TICK_DIV=8, 8 cycles run → sec=1 one edge after tick; upd_done pulses once; busy high for 1 cycle.
- Preload 23:59:59, day 31, month 12, year 99; one tick → edges k+1..k+6 give 00:00:00, day 1, month 1, year 0; busy for 6 cycles; then a single upd_done.
- LEAP_EN defined: year 4, Feb 28 23:59:59, tick → day 29. Year 5, same stimulus → Mar 1. LEAP_EN undefined, year 4 → Mar 1.
- set_mode=1, field_sel=4, month 3, day 31, dec → month 2, then CLAMP → day 28 (29 if LEAP_EN and year 0); upd_done once.
- set_mode=1, field_sel=1, min 0: dec → 59, hour unchanged; inc and dec together → no change; field_sel=7 with inc → no change.
- rst asserted during the MIN stage of a carry chain → next edge shows all reset values and busy=0; no upd_done.

Source files
------------

// File: rtl/time_update_seq.sv
// Time-of-day/date update sequencer: 1 Hz prescaler, one-field-per-clock carry chain, SET-mode adjust.
// Optional leap-year February (29 days when year offset mod 4 == 0) via `define TIME_UPDATE_SEQ_LEAP_EN.
module time_update_seq #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int YEAR_SPAN = 100,
    parameter int YEAR_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_mode,
    input  logic [2:0]        field_sel,
    input  logic              inc,
    input  logic              dec,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [4:0]        hour,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              busy,
    output logic              upd_done,
    output logic [2:0]        state_o
);

    localparam int CNT_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEC   = 3'd1,
        MIN   = 3'd2,
        HOUR  = 3'd3,
        DAY   = 3'd4,
        MON   = 3'd5,
        YEAR  = 3'd6,
        CLAMP = 3'd7
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pre_cnt;
    logic             tick;
    logic             edit_ok;
    logic [4:0]       feb_days;
    logic [4:0]       dim;

    assign state_o = state;

    // Prescaler only runs outside SET mode, so leaving SET always restarts a full second.
    assign tick = !set_mode && (pre_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || set_mode)
            pre_cnt <= '0;
        else if (pre_cnt == CNT_W'(TICK_DIV - 1))
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + CNT_W'(1);
    end

`ifdef TIME_UPDATE_SEQ_LEAP_EN
    assign feb_days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
`else
    assign feb_days = 5'd28;
`endif

    // Shared by run-mode carry, SET day wrap and CLAMP so all three agree.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [4:0] feb);
        case (m)
            4'd2:                      return feb;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    assign dim = days_in_month(month, feb_days);

    function automatic logic [15:0] wrap_step(input logic [15:0] v, input logic [15:0] lo,
                                              input logic [15:0] hi, input logic up);
        if (up)
            return (v >= hi) ? lo : v + 16'd1;
        else
            return (v <= lo) ? hi : v - 16'd1;
    endfunction

    assign edit_ok = set_mode && (inc ^ dec) && (field_sel < 3'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sec      <= '0;
            min      <= '0;
            hour     <= '0;
            day      <= 5'd1;
            month    <= 4'd1;
            year     <= '0;
            busy     <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SEC;
                        busy  <= 1'b1;
                    end else if (edit_ok) begin
                        // Edits wrap inside the field; no carry into neighbours.
                        case (field_sel)
                            3'd0: sec   <= 6'(wrap_step(16'(sec), 16'd0, 16'd59, inc));
                            3'd1: min   <= 6'(wrap_step(16'(min), 16'd0, 16'd59, inc));
                            3'd2: hour  <= 5'(wrap_step(16'(hour), 16'd0, 16'd23, inc));
                            3'd3: day   <= 5'(wrap_step(16'(day), 16'd1, 16'(dim), inc));
                            3'd4: month <= 4'(wrap_step(16'(month), 16'd1, 16'd12, inc));
                            3'd5: year  <= YEAR_W'(wrap_step(16'(year), 16'd0,
                                                             16'(YEAR_SPAN - 1), inc));
                            default: ;
                        endcase
                        state <= CLAMP;
                        busy  <= 1'b1;
                    end
                end
                SEC: begin
                    if (sec == 6'd59) begin
                        sec   <= '0;
                        state <= MIN;
                    end else begin
                        sec      <= sec + 6'd1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        upd_done <= 1'b1;
                    end
                end
                MIN: begin
                    if (min == 6'd59) begin
                        min   <= '0;
                        state <= HOUR;
                    end else begin
                        min      <= min + 6'd1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        upd_done <= 1'b1;
                    end
                end
                HOUR: begin
                    if (hour == 5'd23) begin
                        hour  <= '0;
                        state <= DAY;
                    end else begin
                        hour     <= hour + 5'd1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        upd_done <= 1'b1;
                    end
                end
                DAY: begin
                    if (day >= dim) begin
                        day   <= 5'd1;
                        state <= MON;
                    end else begin
                        day      <= day + 5'd1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        upd_done <= 1'b1;
                    end
                end
                MON: begin
                    if (month == 4'd12) begin
                        month <= 4'd1;
                        state <= YEAR;
                    end else begin
                        month    <= month + 4'd1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        upd_done <= 1'b1;
                    end
                end
                YEAR: begin
                    if (year == YEAR_W'(YEAR_SPAN - 1))
                        year <= '0;
                    else
                        year <= year + YEAR_W'(1);
                    state    <= IDLE;
                    busy     <= 1'b0;
                    upd_done <= 1'b1;
                end
                CLAMP: begin
                    // A month/year edit can leave day past the new month's end.
                    if (day > dim)
                        day <= dim;
                    state    <= IDLE;
                    busy     <= 1'b0;
                    upd_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_update_seq.sv
// Directed self-checking bench for time_update_seq (TICK_DIV=8); leap expectations follow TIME_UPDATE_SEQ_LEAP_EN.
module tb_time_update_seq;

    localparam int TICK_DIV  = 8;
    localparam int YEAR_SPAN = 100;
    localparam int YEAR_W    = 7;
`ifdef TIME_UPDATE_SEQ_LEAP_EN
    localparam bit LEAP = 1'b1;
`else
    localparam bit LEAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, set_mode, inc, dec;
    logic [2:0]        field_sel;
    logic [5:0]        sec, min;
    logic [4:0]        hour, day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic              busy, upd_done;
    logic [2:0]        state_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    time_update_seq #(.TICK_DIV(TICK_DIV), .YEAR_SPAN(YEAR_SPAN), .YEAR_W(YEAR_W)) dut (
        .clk(clk), .rst(rst), .set_mode(set_mode), .field_sel(field_sel), .inc(inc), .dec(dec),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .busy(busy), .upd_done(upd_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit sm);
        rst = 1'b1; set_mode = sm; inc = 1'b0; dec = 1'b0; field_sel = 3'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic edit(input logic [2:0] sel, input bit up);
        field_sel = sel; inc = up; dec = !up;
        step();
        chk("edit_busy", 32'(busy), 32'd1);
        inc = 1'b0; dec = 1'b0;
        step();
        chk("edit_done", 32'(upd_done), 32'd1);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s,
                            input int d, input int mo, input int y);
        chk({tag, "_hour"},  32'(hour),  32'(h));
        chk({tag, "_min"},   32'(min),   32'(m));
        chk({tag, "_sec"},   32'(sec),   32'(s));
        chk({tag, "_day"},   32'(day),   32'(d));
        chk({tag, "_month"}, 32'(month), 32'(mo));
        chk({tag, "_year"},  32'(year),  32'(y));
    endtask

    // Leave SET mode and count edges until the tick launches the chain.
    task automatic run_tick(input string tag);
        int k;
        set_mode = 1'b0;
        k = 0;
        while (!busy && k < 40) begin
            step();
            k++;
        end
        chk({tag, "_tick_lat"}, 32'(k), 32'(TICK_DIV));
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state and a single tick
        do_reset(1'b0);
        chk_time("rst", 0, 0, 0, 1, 1, 0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_upd", 32'(upd_done), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        run_tick("t1");
        chk("t1_sec_pre", 32'(sec), 32'd0);
        step();
        chk("t1_sec", 32'(sec), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_upd", 32'(upd_done), 32'd1);
        step();
        chk("t1_upd_once", 32'(upd_done), 32'd0);

        // Full rollover 23:59:59 12/31/99
        do_reset(1'b1);
        edit(3'd0, 1'b0);
        edit(3'd1, 1'b0);
        edit(3'd2, 1'b0);
        edit(3'd3, 1'b0);
        edit(3'd4, 1'b0);
        edit(3'd5, 1'b0);
        chk_time("roll_pre", 23, 59, 59, 31, 12, 99);
        run_tick("roll");
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("roll_busy", 32'(busy), (i < 6) ? 32'd1 : 32'd0);
            chk("roll_upd", 32'(upd_done), (i == 6) ? 32'd1 : 32'd0);
        end
        chk_time("roll", 0, 0, 0, 1, 1, 0);
        set_mode = 1'b1;
        step();
        chk("roll_upd_once", 32'(upd_done), 32'd0);

        // Feb 28 23:59:59, year 4
        do_reset(1'b1);
        repeat (4) edit(3'd5, 1'b1);
        edit(3'd4, 1'b1);
        repeat (27) edit(3'd3, 1'b1);
        edit(3'd2, 1'b0);
        edit(3'd1, 1'b0);
        edit(3'd0, 1'b0);
        chk_time("leap4_pre", 23, 59, 59, 28, 2, 4);
        run_tick("leap4");
        wait_idle(n);
        chk("leap4_len", 32'(n), LEAP ? 32'd4 : 32'd5);
        chk_time("leap4", 0, 0, 0, LEAP ? 29 : 1, LEAP ? 2 : 3, 4);

        // Feb 28 23:59:59, year 5
        do_reset(1'b1);
        repeat (5) edit(3'd5, 1'b1);
        edit(3'd4, 1'b1);
        repeat (27) edit(3'd3, 1'b1);
        edit(3'd2, 1'b0);
        edit(3'd1, 1'b0);
        edit(3'd0, 1'b0);
        run_tick("leap5");
        wait_idle(n);
        chk_time("leap5", 0, 0, 0, 1, 3, 5);

        // Month edit 3 -> 2 with day 31 clamps
        do_reset(1'b1);
        edit(3'd4, 1'b1);
        edit(3'd4, 1'b1);
        edit(3'd3, 1'b0);
        chk("clamp_pre_day", 32'(day), 32'd31);
        field_sel = 3'd4; dec = 1'b1;
        step();
        dec = 1'b0;
        chk("clamp_month", 32'(month), 32'd2);
        chk("clamp_day_pre", 32'(day), 32'd31);
        chk("clamp_state", 32'(state_o), 32'd7);
        chk("clamp_upd_pre", 32'(upd_done), 32'd0);
        step();
        chk("clamp_day", 32'(day), LEAP ? 32'd29 : 32'd28);
        chk("clamp_upd", 32'(upd_done), 32'd1);
        chk("clamp_busy", 32'(busy), 32'd0);
        step();
        chk("clamp_upd_once", 32'(upd_done), 32'd0);

        // Minute wrap down, ignored requests
        do_reset(1'b1);
        edit(3'd1, 1'b0);
        chk("nop_min", 32'(min), 32'd59);
        chk("nop_hour", 32'(hour), 32'd0);
        field_sel = 3'd1; inc = 1'b1; dec = 1'b1;
        step();
        inc = 1'b0; dec = 1'b0;
        chk("both_busy", 32'(busy), 32'd0);
        chk("both_state", 32'(state_o), 32'd0);
        chk("both_min", 32'(min), 32'd59);
        field_sel = 3'd7; inc = 1'b1;
        step();
        inc = 1'b0;
        chk("sel7_busy", 32'(busy), 32'd0);
        chk("sel7_upd", 32'(upd_done), 32'd0);
        chk_time("sel7", 0, 59, 0, 1, 1, 0);
        // inc held through CLAMP: only the first edge counts
        field_sel = 3'd0; inc = 1'b1;
        step();
        step();
        inc = 1'b0;
        step();
        chk("drop_sec", 32'(sec), 32'd1);

        // Reset during MIN stage
        do_reset(1'b1);
        edit(3'd0, 1'b0);
        run_tick("mid");
        step();
        chk("mid_state", 32'(state_o), 32'd2);
        chk("mid_sec", 32'(sec), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_time("mid_rst", 0, 0, 0, 1, 1, 0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_upd", 32'(upd_done), 32'd0);
        chk("mid_state_rst", 32'(state_o), 32'd0);
        step();
        chk("mid_upd_after", 32'(upd_done), 32'd0);
        chk("mid_min_after", 32'(min), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
